// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory-port arbiter.
// Package name is mem_arb_pkg; imported by mem_port_arbiter.
package mem_arb_pkg;

  // Ownership state of the shared memory port
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_e;

  // mem_sel encodings: which requester currently owns the port
  localparam logic SEL_I = 1'b0;
  localparam logic SEL_D = 1'b1;

endpackage

// File: rtl/Nbit_Mux.sv
// Generic n-bit 2:1 multiplexer used for address steering.
module Nbit_Mux #(
  parameter int n = 32
) (
  input  logic         sel,
  input  logic [n-1:0] in0,
  input  logic [n-1:0] in1,
  output logic [n-1:0] out
);

  assign out = sel ? in1 : in0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter/sequencer for the single shared memory port.
// Fetch (I) and load/store (D) requesters; D wins out of IDLE, and the
// requester just served is skipped in its completion cycle so that the
// two alternate under contention with no bubble between grants.
// Optional build macro ARB_TIMEOUT_EN adds a grant wait-timeout that
// pulses arb_err and abandons the access; without it arb_err is 0 and a
// grant waits for mem_ready indefinitely.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              arb_err
);

  arb_state_e        state;
  arb_state_e        state_nxt;
  logic              sel_q;
  logic              granted;
  logic              timeout;
  logic [ADDR_W-1:0] addr_mux;

  assign granted = (state != IDLE);

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] wait_cnt;

  // Wait counter: restarts whenever the grant changes, counts stalled grant cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state_nxt != state) begin
      wait_cnt <= '0;
    end else if (granted && !mem_ready) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timeout = granted && !mem_ready && (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign timeout = 1'b0;
`endif

  // Next-state: D priority from IDLE, hand over to the other requester on completion
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (d_req)      state_nxt = GNT_D;
        else if (i_req) state_nxt = GNT_I;
      end
      GNT_I: begin
        if (timeout)        state_nxt = IDLE;
        else if (mem_ready) state_nxt = d_req ? GNT_D : IDLE;
      end
      GNT_D: begin
        if (timeout)        state_nxt = IDLE;
        else if (mem_ready) state_nxt = i_req ? GNT_I : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset abandons any in-flight access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Select register: only moves when a new grant is taken, holds through IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  sel_q <= SEL_I;
    else if (state_nxt == GNT_I) sel_q <= SEL_I;
    else if (state_nxt == GNT_D) sel_q <= SEL_D;
  end

  Nbit_Mux #(
    .n (ADDR_W)
  ) u_addr_mux (
    .sel (sel_q),
    .in0 (i_addr),
    .in1 (d_addr),
    .out (addr_mux)
  );

  // Memory-side outputs are zeroed while no one owns the port
  assign mem_req   = granted;
  assign mem_sel   = sel_q;
  assign mem_addr  = granted ? addr_mux : '0;
  assign mem_we    = (state == GNT_D) && d_we;
  assign mem_wdata = granted ? d_wdata : '0;

  // Completion pulses; a timed-out grant never has mem_ready, so no pulse
  assign i_ready = (state == GNT_I) && mem_ready;
  assign d_ready = (state == GNT_D) && mem_ready;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;
  assign arb_err = timeout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized phase, all checked cycle by cycle against an ownership model.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
`ifdef ARB_TIMEOUT_EN
  localparam int TIMEOUT = 4;
`else
  localparam int TIMEOUT = 16;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ready;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ready;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_req;
  logic              mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;
  logic              arb_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_ready   (i_ready),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ready   (d_ready),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_sel   (mem_sel),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .arb_err   (arb_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who owns the port (0 none, 1 fetch, 2 data)
  int   owner;
  logic last_sel;
  int   wait_cycles;
  logic exp_i_rdy;
  logic exp_d_rdy;

  // Observed pulse counters from the DUT
  int          dut_i_pulses = 0;
  int          dut_d_pulses = 0;
  int          dut_err_pulses = 0;
  logic [31:0] dut_i_rdata_cap = '0;

  always @(negedge clk) begin
    if (i_ready === 1'b1) begin
      dut_i_pulses++;
      dut_i_rdata_cap = i_rdata;
    end
    if (d_ready === 1'b1) dut_d_pulses++;
    if (arb_err === 1'b1) dut_err_pulses++;
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner       = 0;
    last_sel    = 1'b0;
    wait_cycles = 0;
    exp_i_rdy   = 1'b0;
    exp_d_rdy   = 1'b0;
  endtask

  // One clock: check outputs mid-cycle against the model, then advance it
  task automatic step();
    int   nxt;
    logic err;
    @(negedge clk);
    err = 1'b0;
`ifdef ARB_TIMEOUT_EN
    err = (owner != 0) && !mem_ready && (wait_cycles == TIMEOUT - 1);
`endif
    exp_i_rdy = (owner == 1) && mem_ready;
    exp_d_rdy = (owner == 2) && mem_ready;
    check_val("mem_req", mem_req, owner != 0);
    check_val("mem_sel", mem_sel, (owner == 2) ? 1'b1 : (owner == 1) ? 1'b0 : last_sel);
    check_val("i_ready", i_ready, exp_i_rdy);
    check_val("d_ready", d_ready, exp_d_rdy);
    check_val("arb_err", arb_err, err);
    check_val("mem_we", mem_we, (owner == 2) && d_we);
    if (owner == 1) begin
      check_val("i_req_held", i_req, 1'b1);
      check_val("mem_addr_i", mem_addr, i_addr);
    end
    if (owner == 2) begin
      check_val("d_req_held", d_req, 1'b1);
      check_val("mem_addr_d", mem_addr, d_addr);
      check_val("mem_wdata", mem_wdata, d_wdata);
    end
    if (exp_i_rdy) check_val("i_rdata", i_rdata, mem_rdata);
    if (exp_d_rdy) check_val("d_rdata", d_rdata, mem_rdata);

    nxt = owner;
    if (owner == 0)      nxt = d_req ? 2 : (i_req ? 1 : 0);
    else if (err)        nxt = 0;
    else if (mem_ready)  nxt = (owner == 1) ? (d_req ? 2 : 0) : (i_req ? 1 : 0);

    @(posedge clk);
    if (nxt != owner)     wait_cycles = 0;
    else if (owner != 0)  wait_cycles++;
    if (nxt == 1)      last_sel = 1'b0;
    else if (nxt == 2) last_sel = 1'b1;
    owner = nxt;
    #1;
  endtask

  // Requesters react to a completion: drop, or optionally start a new request
  task automatic service(input bit refill);
    if (exp_i_rdy) begin
      i_req  = refill ? ($urandom_range(0, 1) == 1) : 1'b0;
      i_addr = $urandom;
    end
    if (exp_d_rdy) begin
      d_req   = refill ? ($urandom_range(0, 1) == 1) : 1'b0;
      d_we    = ($urandom_range(0, 1) == 1);
      d_addr  = $urandom;
      d_wdata = $urandom;
    end
    exp_i_rdy = 1'b0;
    exp_d_rdy = 1'b0;
  endtask

  initial begin
    int p0;
    model_reset();
    rst_n     = 1'b0;
    i_req     = 1'b1;
    d_req     = 1'b1;
    i_addr    = 32'h0000_0080;
    d_addr    = 32'h0000_0040;
    d_we      = 1'b0;
    d_wdata   = 32'h0000_00A5;
    mem_ready = 1'b1;
    mem_rdata = 32'h0;

    // Reset held with both requests pending
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_mem_req", mem_req, 1'b0);
    check_val("rst_mem_sel", mem_sel, 1'b0);
    check_val("rst_mem_we", mem_we, 1'b0);
    check_val("rst_mem_addr", mem_addr, 32'h0);
    check_val("rst_mem_wdata", mem_wdata, 32'h0);
    check_val("rst_i_ready", i_ready, 1'b0);
    check_val("rst_d_ready", d_ready, 1'b0);
    check_val("rst_arb_err", arb_err, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    step();
    check_val("post_rst_sel_d", mem_sel, 1'b1);
    check_val("post_rst_addr_d", mem_addr, 32'h0000_0040);
    step(); service(1'b0);
    step(); service(1'b0);
    step();

    // Single fetch with three stalled cycles
    i_req = 1'b1; i_addr = 32'h100; mem_ready = 1'b0;
    p0 = dut_i_pulses;
    step();
    repeat (3) step();
    mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step(); service(1'b0);
    mem_ready = 1'b0;
    step(); step();
    check_val("fetch_pulses", dut_i_pulses - p0, 1);
    check_val("fetch_rdata", dut_i_rdata_cap, 32'hDEAD_BEEF);

    // Contention with memory always ready: D, I, D, I ... no bubbles
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; mem_ready = 1'b1;
    step();
    for (int k = 0; k < 6; k++) begin
      check_val("cont_req", mem_req, 1'b1);
      check_val("cont_sel", mem_sel, (k % 2 == 0) ? 1'b1 : 1'b0);
      step();
    end
    repeat (3) begin step(); service(1'b0); end

    // Store
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'h1234_5678; mem_ready = 1'b0;
    step();
    check_val("st_we", mem_we, 1'b1);
    check_val("st_sel", mem_sel, 1'b1);
    check_val("st_wdata", mem_wdata, 32'h1234_5678);
    check_val("st_rdy_early", d_ready, 1'b0);
    step();
    mem_ready = 1'b1;
    #1 check_val("st_rdy_with_mem", d_ready, 1'b1);
    step(); service(1'b0);
    d_we = 1'b0; mem_ready = 1'b0;
    step();

    // Reset in the middle of a fetch grant
    i_req = 1'b1; i_addr = 32'h300; mem_ready = 1'b0;
    step();
    check_val("mid_granted", mem_req, 1'b1);
    p0 = dut_i_pulses;
    mem_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check_val("mid_rst_req", mem_req, 1'b0);
    check_val("mid_rst_irdy", i_ready, 1'b0);
    model_reset();
    i_req = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_val("mid_rst_nopulse", dut_i_pulses - p0, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();

`ifdef ARB_TIMEOUT_EN
    // Stuck memory: timeout after TIMEOUT grant cycles, then re-grant
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4000; mem_ready = 1'b0;
    p0 = dut_err_pulses;
    step();
    repeat (TIMEOUT) step();
    check_val("to_err_pulse", dut_err_pulses - p0, 1);
    check_val("to_idle", mem_req, 1'b0);
    step();
    check_val("to_regrant_req", mem_req, 1'b1);
    check_val("to_regrant_sel", mem_sel, 1'b1);
    mem_ready = 1'b1;
    step(); service(1'b0);
    mem_ready = 1'b0;
    step();
`endif

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      if (!i_req && $urandom_range(0, 3) == 0) begin
        i_req = 1'b1; i_addr = $urandom;
      end
      if (!d_req && $urandom_range(0, 3) == 0) begin
        d_req = 1'b1; d_we = ($urandom_range(0, 1) == 1); d_addr = $urandom; d_wdata = $urandom;
      end
      mem_ready = ($urandom_range(0, 1) == 1);
      mem_rdata = $urandom;
      step();
      service(1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the single shared memory port. It grants the port to either the instruction-fetch requester (I) or the data load/store requester (D) and drives the 2:1 address select, `mem_sel`. It holds each grant until the memory acknowledges, then re-arbitrates with the just-served requester excluded for that cycle. It sits between the fetch/LSU logic and the unified memory.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `TIMEOUT`, 16, maximum cycles a grant may wait for `mem_ready` (only with `ARB_TIMEOUT_EN`)

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `i_req`  in  1  fetch request; held high until `i_ready`
- `i_addr`  in  ADDR_W  fetch address; stable while `i_req` is high
- `i_ready`  out  1  one-cycle completion pulse to fetch
- `i_rdata`  out  DATA_W  fetch data; valid only while `i_ready` is high
- `d_req`  in  1  data request; held high until `d_ready`
- `d_we`  in  1  1 = store, 0 = load; stable with `d_req`
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_ready`  out  1  one-cycle completion pulse to LSU
- `d_rdata`  out  DATA_W  load data; valid only while `d_ready` is high
- `mem_req`  out  1  access strobe to memory
- `mem_sel`  out  1  0 = I owns the port, 1 = D owns the port
- `mem_addr`  out  ADDR_W  steered address
- `mem_we`  out  1  `d_we` when D is granted, else 0
- `mem_wdata`  out  DATA_W  `d_wdata` (don't-care when I is granted)
- `mem_ready`  in  1  memory completion for the current access
- `mem_rdata`  in  DATA_W  memory read data, valid with `mem_ready`
- `arb_err`  out  1  one-cycle timeout pulse (tied 0 without `ARB_TIMEOUT_EN`)

## Operation
- FSM states are IDLE, GNT_I and GNT_D. The state is registered.
- IDLE:
  - `d_req` → GNT_D.
  - Else `i_req` → GNT_I.
  - Else stay in IDLE.
  - D has fixed priority out of IDLE.
- GNT_x:
  - `mem_req` = 1 and `mem_sel` = x.
  - On `mem_ready`: `x_ready` = 1 in the same cycle, and `x_rdata` = `mem_rdata`.
  - Next state is GNT_(other) if the other requester's req is high, else IDLE.
  - The served requester is never re-granted in its completion cycle, because its req is still high then. This gives alternation under contention.
- `mem_sel` keeps its last value in IDLE and does not toggle without a grant.
- `mem_addr`, `mem_we` and `mem_wdata` are muxed combinationally from `mem_sel`.
- `i_ready` and `d_ready` are never high in the same cycle.
- Dropping req while granted is illegal. The grant stays until `mem_ready`, and a bench assertion flags the violation.

## Timing
- Reset (asynchronous, while `rst_n` = 0):
  - State is IDLE.
  - `mem_req`, `mem_sel`, `mem_we`, `i_ready`, `d_ready` and `arb_err` are 0.
  - `mem_addr` and `mem_wdata` are 0.
- Reset mid-access drops `mem_req` immediately. The in-flight access is abandoned and no ready pulse is issued.
- Latency from IDLE: req high at cycle N → `mem_req` at N+1.
  - With `mem_ready` at N+1, ready also pulses at N+1.
  - Minimum service is therefore 2 cycles from IDLE.
- Back-to-back under contention costs 0 bubble cycles: the completion cycle of one grant is followed directly by the other grant.
- `x_ready` is combinational from `mem_ready` and the state. `x_rdata` is combinational from `mem_rdata`.

## Configuration
- With `ARB_TIMEOUT_EN` defined:
  - A wait counter clears on entry to a GNT state and increments each GNT cycle without `mem_ready`.
  - When the count reaches `TIMEOUT` − 1 without `mem_ready`, the arbiter:
    - pulses `arb_err` for 1 cycle,
    - raises no ready pulse,
    - moves to IDLE.
  - The requester's req is still high, so it re-arbitrates from IDLE normally.
  - The counter is `$clog2(TIMEOUT)` bits and resets to 0.
- Without `ARB_TIMEOUT_EN`: no counter, `arb_err` is tied to 0, and a grant waits indefinitely.

## Structure
- Package `mem_arb_pkg`:
  - state enum {IDLE, GNT_I, GNT_D}
  - constants `SEL_I` = 1'b0 and `SEL_D` = 1'b1
- Address steering instantiates the existing `Nbit_Mux` (n = `ADDR_W`), with select `mem_sel`. Write-data steering needs no mux, because only D writes.
- The timeout counter is inline, guarded by `ARB_TIMEOUT_EN`. No other sub-module.

## Test plan
- Reset: hold `rst_n` = 0 with `i_req` = `d_req` = 1 → `mem_req` = 0 and `mem_sel` = 0. Release → GNT_D next cycle with `mem_addr` = `d_addr`.
- Single fetch: `i_req` = 1, `i_addr` = 0x100, memory ready after 3 cycles with rdata 0xDEADBEEF → `i_ready` pulses once, `i_rdata` = 0xDEADBEEF, `mem_we` = 0 throughout.
- Contention: `i_req` and `d_req` raised together, `mem_ready` always 1 → grant order D, I, D, I… with no idle cycle between grants.
- Store: `d_we` = 1, `d_addr` = 0x2000, `d_wdata` = 0x12345678 → `mem_we` = 1, `mem_sel` = 1, `d_ready` coincides with `mem_ready`.
- Reset mid-access: assert `rst_n` = 0 during GNT_I before `mem_ready` → `mem_req` drops asynchronously and no `i_ready` pulse occurs.
- Timeout (`ARB_TIMEOUT_EN`, `TIMEOUT` = 4): `d_req` held, `mem_ready` stuck 0 → `arb_err` pulses after 4 GNT_D cycles, the arbiter returns to IDLE, then re-grants D.
